// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: debounces a multiplexed 8-digit seven-segment scan and decodes the HH.MM.SS frame.
// Optional macro SEG_SCAN_DECODER_TICK_CHECK_EN adds o_tick_err (time did not hold or advance by 1 s).
module seg_scan_decoder #(
    parameter bit CS_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_cs,
    input  logic [7:0] i_dig_sel,
    output logic       o_valid,
    output logic [4:0] o_hh,
    output logic [5:0] o_mm,
    output logic [5:0] o_ss,
    output logic       o_err,
    output logic       o_lost
`ifdef SEG_SCAN_DECODER_TICK_CHECK_EN
    ,
    output logic       o_tick_err
`endif
);

    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [7:0]      STAB    = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_CHECK} state_t;

    // Bit 4 of the result flags a code that is not a decimal digit.
    function automatic logic [4:0] decodeSeg(input logic [6:0] seg);
        case (seg)
            7'h3F:   decodeSeg = 5'd0;
            7'h06:   decodeSeg = 5'd1;
            7'h5B:   decodeSeg = 5'd2;
            7'h4F:   decodeSeg = 5'd3;
            7'h66:   decodeSeg = 5'd4;
            7'h6D:   decodeSeg = 5'd5;
            7'h7D:   decodeSeg = 5'd6;
            7'h07:   decodeSeg = 5'd7;
            7'h7F:   decodeSeg = 5'd8;
            7'h6F:   decodeSeg = 5'd9;
            default: decodeSeg = 5'h10;
        endcase
    endfunction

    logic [7:0]      w_cs_n;
    logic [7:0]      w_seg_n;
    logic [15:0]     w_sample;
    logic            w_selecting;
    logic            w_same;
    logic [7:0]      w_stab_next;
    logic            w_capture;
    logic [2:0]      w_pos;
    logic [4:0]      w_dec;
    logic            w_pos_bad;
    logic            w_timeout;

    logic [15:0]     r_prev;
    logic [7:0]      r_stab;
    logic [TO_W-1:0] r_to;
    state_t          r_state;
    state_t          w_state_next;
    logic [7:0]      r_bitmap;
    logic [7:0][3:0] r_digit;
    logic [7:0]      r_bad;

    logic            w_start;
    logic            w_store;
    logic            w_clear;
    logic            w_restart_err;
    logic            w_check_good;
    logic            w_check_bad;
    logic [6:0]      w_hh7;
    logic [6:0]      w_mm7;
    logic [6:0]      w_ss7;
    logic            w_frame_good;

    assign w_cs_n      = CS_ACTIVE_LOW  ? ~i_cs      : i_cs;
    assign w_seg_n     = SEG_ACTIVE_LOW ? ~i_dig_sel : i_dig_sel;
    assign w_sample    = {w_cs_n, w_seg_n};
    assign w_selecting = (w_cs_n != 8'd0) && ((w_cs_n & (w_cs_n - 8'd1)) == 8'd0);
    assign w_same      = (w_sample == r_prev);

    // The counter saturates so a position held for a very long time never recaptures.
    always_comb begin
        w_stab_next = 8'd0;
        if (w_selecting && w_same)
            w_stab_next = (r_stab == 8'hFF) ? r_stab : r_stab + 8'd1;
        else if (w_selecting)
            w_stab_next = 8'd1;
    end

    assign w_capture = w_selecting && (w_stab_next == STAB) && !(w_same && (r_stab == STAB));
    assign w_timeout = !w_capture && (r_to == TO_LAST);

    always_comb begin
        w_pos = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (w_cs_n[k])
                w_pos = 3'(k);
        end
    end

    // Separators must show a lit '0' with its dot; elsewhere the dot is ignored.
    always_comb begin
        w_dec     = decodeSeg(w_seg_n[6:0]);
        w_pos_bad = w_dec[4];
        if (w_pos == 3'd2 || w_pos == 3'd5)
            w_pos_bad = (w_seg_n != 8'hBF);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= 16'd0;
            r_stab <= 8'd0;
            r_to   <= '0;
        end else begin
            r_prev <= w_sample;
            r_stab <= w_stab_next;
            if (w_capture)
                r_to <= '0;
            else if (r_to != TO_MAX)
                r_to <= r_to + TO_W'(1);
        end
    end

    assign w_hh7 = 7'(r_digit[0]) * 7'd10 + 7'(r_digit[1]);
    assign w_mm7 = 7'(r_digit[3]) * 7'd10 + 7'(r_digit[4]);
    assign w_ss7 = 7'(r_digit[6]) * 7'd10 + 7'(r_digit[7]);
    assign w_frame_good = (r_bad == 8'd0) && (w_hh7 < 7'd24) && (w_mm7 < 7'd60) && (w_ss7 < 7'd60);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // A position-0 capture during CHECK opens the next frame straight away.
    always_comb begin
        w_state_next  = r_state;
        w_start       = 1'b0;
        w_store       = 1'b0;
        w_clear       = 1'b0;
        w_restart_err = 1'b0;
        w_check_good  = 1'b0;
        w_check_bad   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_capture && w_pos == 3'd0) begin
                    w_start      = 1'b1;
                    w_state_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_capture && w_pos == 3'd0) begin
                    w_start       = 1'b1;
                    w_restart_err = 1'b1;
                end else if (w_capture && !r_bitmap[w_pos]) begin
                    w_store = 1'b1;
                    if ((r_bitmap | (8'd1 << w_pos)) == 8'hFF)
                        w_state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                w_check_good = w_frame_good;
                w_check_bad  = !w_frame_good;
                w_clear      = 1'b1;
                w_state_next = S_IDLE;
                if (w_capture && w_pos == 3'd0) begin
                    w_start      = 1'b1;
                    w_state_next = S_COLLECT;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (w_timeout) begin
            w_clear      = 1'b1;
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bitmap <= 8'd0;
            r_digit  <= '0;
            r_bad    <= 8'd0;
        end else if (w_start) begin
            r_bitmap   <= 8'h01;
            r_bad      <= {7'd0, w_pos_bad};
            r_digit[0] <= w_dec[3:0];
        end else if (w_store) begin
            r_bitmap[w_pos] <= 1'b1;
            r_bad[w_pos]    <= w_pos_bad;
            r_digit[w_pos]  <= w_dec[3:0];
        end else if (w_clear) begin
            r_bitmap <= 8'd0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_err   <= 1'b0;
            o_lost  <= 1'b0;
            o_hh    <= 5'd0;
            o_mm    <= 6'd0;
            o_ss    <= 6'd0;
        end else begin
            o_valid <= w_check_good;
            o_err   <= w_check_bad | w_restart_err;
            if (w_capture)
                o_lost <= 1'b0;
            else if (w_timeout)
                o_lost <= 1'b1;
            if (w_check_good) begin
                o_hh <= w_hh7[4:0];
                o_mm <= w_mm7[5:0];
                o_ss <= w_ss7[5:0];
            end
        end
    end

`ifdef SEG_SCAN_DECODER_TICK_CHECK_EN
    logic       r_have_last;
    logic [4:0] w_inc_hh;
    logic [5:0] w_inc_mm;
    logic [5:0] w_inc_ss;
    logic       w_same_time;
    logic       w_next_time;

    // The held outputs are the previous good time; derive its +1 s successor.
    always_comb begin
        w_inc_ss = o_ss + 6'd1;
        w_inc_mm = o_mm;
        w_inc_hh = o_hh;
        if (o_ss == 6'd59) begin
            w_inc_ss = 6'd0;
            w_inc_mm = o_mm + 6'd1;
            if (o_mm == 6'd59) begin
                w_inc_mm = 6'd0;
                w_inc_hh = (o_hh == 5'd23) ? 5'd0 : o_hh + 5'd1;
            end
        end
    end

    assign w_same_time = ({w_hh7[4:0], w_mm7[5:0], w_ss7[5:0]} == {o_hh, o_mm, o_ss});
    assign w_next_time = ({w_hh7[4:0], w_mm7[5:0], w_ss7[5:0]} == {w_inc_hh, w_inc_mm, w_inc_ss});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_have_last <= 1'b0;
            o_tick_err  <= 1'b0;
        end else begin
            o_tick_err <= w_check_good && r_have_last && !w_same_time && !w_next_time;
            if (w_timeout)
                r_have_last <= 1'b0;
            else if (w_check_good)
                r_have_last <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomised self-checking bench for seg_scan_decoder against a frame-level reference model.
// Honours SEG_SCAN_DECODER_TICK_CHECK_EN when the design is built with it.
module tb_seg_scan_decoder;

    localparam bit CS_ACTIVE_LOW  = 1'b1;
    localparam int STABLE_CYCLES  = 4;
    localparam int TIMEOUT_CYCLES = 300;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [7:0] i_cs = 8'hFF;
    logic [7:0] i_dig_sel = 8'h00;
    logic       o_valid;
    logic [4:0] o_hh;
    logic [5:0] o_mm;
    logic [5:0] o_ss;
    logic       o_err;
    logic       o_lost;
`ifdef SEG_SCAN_DECODER_TICK_CHECK_EN
    logic       o_tick_err;
`endif

    seg_scan_decoder #(
        .CS_ACTIVE_LOW (CS_ACTIVE_LOW),
        .SEG_ACTIVE_LOW(1'b0),
        .STABLE_CYCLES (STABLE_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_cs      (i_cs),
        .i_dig_sel (i_dig_sel),
        .o_valid   (o_valid),
        .o_hh      (o_hh),
        .o_mm      (o_mm),
        .o_ss      (o_ss),
        .o_err     (o_err),
        .o_lost    (o_lost)
`ifdef SEG_SCAN_DECODER_TICK_CHECK_EN
        ,
        .o_tick_err(o_tick_err)
`endif
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    int validCnt = 0;
    int errCnt   = 0;
    int tickCnt  = 0;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_valid === 1'b1) validCnt++;
            if (o_err === 1'b1)   errCnt++;
`ifdef SEG_SCAN_DECODER_TICK_CHECK_EN
            if (o_tick_err === 1'b1) tickCnt++;
`endif
        end
    end

    // Reference model state: the frame under assembly and the expected observable results.
    logic [7:0] segCodes [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    logic [7:0] frame [8];
    bit         mCollect = 0;
    bit         mHave [8];
    int         mDig [8];
    bit         mBad [8];
    int         expValid = 0;
    int         expErr = 0;
    int         expTick = 0;
    int         expHh = 0;
    int         expMm = 0;
    int         expSs = 0;
    int         expLost = 0;
    bit         haveGood = 0;
    int         lastT = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int digitOf(input logic [6:0] seg);
        for (int d = 0; d < 10; d++)
            if (segCodes[d][6:0] == seg) return d;
        return -1;
    endfunction

    task automatic buildFrame(input int hh, input int mm, input int ss);
        frame[0] = segCodes[hh / 10]; frame[1] = segCodes[hh % 10];
        frame[2] = 8'hBF;
        frame[3] = segCodes[mm / 10]; frame[4] = segCodes[mm % 10];
        frame[5] = 8'hBF;
        frame[6] = segCodes[ss / 10]; frame[7] = segCodes[ss % 10];
    endtask

    task automatic modelRecord(input int pos, input logic [7:0] seg);
        int d;
        mHave[pos] = 1;
        if (pos == 2 || pos == 5) begin
            mBad[pos] = (seg != 8'hBF);
            mDig[pos] = 0;
        end else begin
            d = digitOf(seg[6:0]);
            mBad[pos] = (d < 0);
            mDig[pos] = (d < 0) ? 0 : d;
        end
    endtask

    task automatic modelStart(input logic [7:0] seg);
        for (int i = 0; i < 8; i++) mHave[i] = 0;
        mCollect = 1;
        modelRecord(0, seg);
    endtask

    task automatic modelEvaluate();
        int hh, mm, ss, t;
        bit bad;
        hh = mDig[0] * 10 + mDig[1];
        mm = mDig[3] * 10 + mDig[4];
        ss = mDig[6] * 10 + mDig[7];
        bad = 0;
        for (int i = 0; i < 8; i++) if (mBad[i]) bad = 1;
        if (bad || hh > 23 || mm > 59 || ss > 59) begin
            expErr++;
        end else begin
            expValid++;
            t = hh * 3600 + mm * 60 + ss;
            if (haveGood && t != lastT && t != (lastT + 1) % 86400) expTick++;
            haveGood = 1;
            lastT = t;
            expHh = hh; expMm = mm; expSs = ss;
        end
        mCollect = 0;
        for (int i = 0; i < 8; i++) mHave[i] = 0;
    endtask

    task automatic modelCapture(input int pos, input logic [7:0] seg);
        bit full;
        expLost = 0;
        if (!mCollect) begin
            if (pos == 0) modelStart(seg);
        end else if (pos == 0) begin
            expErr++;
            modelStart(seg);
        end else if (!mHave[pos]) begin
            modelRecord(pos, seg);
            full = 1;
            for (int i = 0; i < 8; i++) if (!mHave[i]) full = 0;
            if (full) modelEvaluate();
        end
    endtask

    // Holds a raw cs/segment pair for the given number of sampling edges.
    task automatic applyStimulus(input logic [7:0] cs, input logic [7:0] seg, input int cycles);
        i_cs = cs;
        i_dig_sel = seg;
        repeat (cycles) @(posedge i_clk);
        #1;
    endtask

    task automatic scanPos(input int pos, input logic [7:0] seg, input int dwell);
        logic [7:0] sel;
        sel = 8'h01 << pos;
        applyStimulus(CS_ACTIVE_LOW ? ~sel : sel, seg, dwell);
        if (dwell >= STABLE_CYCLES) modelCapture(pos, seg);
    endtask

    task automatic idleCycles(input int n);
        applyStimulus(CS_ACTIVE_LOW ? 8'hFF : 8'h00, 8'h00, n);
        if (n >= TIMEOUT_CYCLES) begin
            mCollect = 0;
            for (int i = 0; i < 8; i++) mHave[i] = 0;
            haveGood = 0;
            expLost = 1;
        end
    endtask

    task automatic scanFrame(input int dwell);
        for (int p = 0; p < 8; p++) scanPos(p, frame[p], dwell);
    endtask

    task automatic checkFrame(input string tag);
        idleCycles(4);
        checkOutput({tag, ".valid"}, validCnt, expValid);
        checkOutput({tag, ".err"}, errCnt, expErr);
        checkOutput({tag, ".time"}, {o_hh, o_mm, o_ss}, (expHh << 12) | (expMm << 6) | expSs);
        checkOutput({tag, ".lost"}, o_lost, expLost);
`ifdef SEG_SCAN_DECODER_TICK_CHECK_EN
        checkOutput({tag, ".tick"}, tickCnt, expTick);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dwell, corruptPos;
        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("reset.valid", o_valid, 0);
        checkOutput("reset.err", o_err, 0);
        checkOutput("reset.time", {o_hh, o_mm, o_ss}, 0);
        checkOutput("reset.lost", o_lost, 0);
`ifdef SEG_SCAN_DECODER_TICK_CHECK_EN
        checkOutput("reset.tick", o_tick_err, 0);
`endif
        i_rst_n = 1'b1;
        idleCycles(3);

        buildFrame(12, 34, 56);
        scanFrame(16);
        checkFrame("good_12_34_56");

        buildFrame(12, 34, 56);
        frame[4] = 8'h00;
        scanFrame(16);
        checkFrame("bad_segment");

        buildFrame(25, 0, 0);
        scanFrame(16);
        checkFrame("hour_range");

        buildFrame(7, 8, 9);
        for (int p = 0; p < 3; p++) scanPos(p, frame[p], 8);
        scanPos(3, frame[3], 3);
        applyStimulus(8'b1111_1100, frame[3], 20);
        checkOutput("glitch.no_valid", validCnt, expValid);
        checkOutput("glitch.no_err", errCnt, expErr);
        for (int p = 3; p < 8; p++) scanPos(p, frame[p], 8);
        checkFrame("glitch_then_dwell");

        buildFrame(11, 11, 11);
        for (int p = 0; p < 5; p++) scanPos(p, frame[p], 8);
        buildFrame(0, 0, 1);
        scanFrame(8);
        checkFrame("restart");

        idleCycles(TIMEOUT_CYCLES + 20);
        checkOutput("timeout.lost", o_lost, 1);
        checkOutput("timeout.hold", {o_hh, o_mm, o_ss}, (expHh << 12) | (expMm << 6) | expSs);

        buildFrame(23, 59, 59); scanFrame(6); checkFrame("tick_first");
        buildFrame(0, 0, 0);    scanFrame(6); checkFrame("tick_wrap");
        buildFrame(0, 0, 0);    scanFrame(6); checkFrame("tick_same");
        buildFrame(0, 0, 5);    scanFrame(6); checkFrame("tick_jump");

        for (int n = 0; n < 16; n++) begin
            buildFrame($urandom_range(0, 26), $urandom_range(0, 61), $urandom_range(0, 61));
            corruptPos = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : -1;
            if (corruptPos >= 0) frame[corruptPos] = 8'($urandom_range(0, 255));
            for (int p = 0; p < 8; p++) begin
                if ($urandom_range(0, 3) == 0)
                    scanPos((p + 1) % 8, 8'($urandom_range(0, 255)), $urandom_range(1, STABLE_CYCLES - 1));
                dwell = $urandom_range(STABLE_CYCLES, 12);
                scanPos(p, frame[p], dwell);
            end
            checkFrame($sformatf("random%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receiver for the multiplexed 8-digit seven-segment scan interface driven by the clock display path (chip select plus segment/dot pattern).
- Samples the scan and debounces each position against ghosting.
- Reassembles a full HH.MM.SS frame and reports the decoded binary time with validity and error flags.
- Used as an on-chip self-check of the display path and as a bench monitor.

Parameters:
- CS_ACTIVE_LOW, 1: i_cs selects a position with a 0 bit when 1, with a 1 bit when 0.
- SEG_ACTIVE_LOW, 0: i_dig_sel is inverted before decoding when 1.
- STABLE_CYCLES, 4: consecutive identical cycles required before a position is captured (range 1..255).
- TIMEOUT_CYCLES, 200000: cycles without any capture before the link is declared lost.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  asynchronous active-low reset
- i_cs  input  8  digit select; bit k selects position k (position 0 = hour tens, left to right)
- i_dig_sel  input  8  segment pattern; bit0..6 = a..g, bit7 = dp
- o_valid  output  1  one-cycle pulse: a good frame was decoded
- o_hh  output  5  hours, 0..23, binary
- o_mm  output  6  minutes, 0..59, binary
- o_ss  output  6  seconds, 0..59, binary
- o_err  output  1  one-cycle pulse: a frame completed but was rejected
- o_lost  output  1  level: no capture within TIMEOUT_CYCLES

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous, active-low, on i_rst_n.
- Reset values: all outputs 0; capture bitmap empty; stability counter 0; state IDLE.
- Normalisation: polarity is normalised first, giving cs_n (active-high) and seg_n (active-high).
- Selection validity: a cycle is "selecting" only when cs_n is exactly one-hot. Zero-hot or multi-hot cycles reset the stability counter and capture nothing.
- Stability counter:
  - Increments while {cs_n, seg_n} equals the previous cycle's value and the cycle is selecting.
  - Otherwise it reloads to 1 (selecting) or 0 (not selecting).
  - Capture of position k occurs in the cycle the counter reaches STABLE_CYCLES.
  - Only one capture per position per frame; a held position does not recapture.
- Digit decode of seg_n[6:0]: 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x7F=8, 0x6F=9. Any other code marks the position bad.
- Separator positions 2 and 5: seg_n[6:0] must be 0x3F with dp=1; otherwise the position is bad. dp on other positions is ignored.
- FSM IDLE:
  - A capture at position 0 stores it, sets bitmap bit 0, and moves to COLLECT.
  - Captures at other positions are discarded.
- FSM COLLECT:
  - A capture stores the digit and sets its bitmap bit.
  - A capture of position 0 while the bitmap is not full discards the partial frame, restarts with position 0 captured, and pulses o_err.
  - When the bitmap becomes full, go to CHECK.
- FSM CHECK (one cycle):
  - hh = d0*10+d1, mm = d3*10+d4, ss = d6*10+d7, computed with 7-bit intermediates.
  - Good frame: no bad position, and hh<24, mm<60, ss<60. Register o_hh/o_mm/o_ss and pulse o_valid.
  - Otherwise pulse o_err and leave the time outputs unchanged.
  - Clear the bitmap and return to IDLE.
- Latency: o_valid/o_err assert exactly 1 cycle after the capture that completes the frame.
- Timeout:
  - The counter resets on every capture.
  - At TIMEOUT_CYCLES it sets o_lost, clears the bitmap, and enters IDLE.
  - o_lost clears on the next capture.
  - Time outputs hold their last good values.
- Reset mid-frame: immediate return to reset values; no pulse is emitted.

Optional Feature:
- Macro: SEG_SCAN_DECODER_TICK_CHECK_EN.
- When defined, adds output o_tick_err (1 bit, reset 0), a one-cycle pulse coincident with o_valid when the new good time is neither equal to the previous good time nor exactly +1 s from it.
  - Wrap rule: 23:59:59 -> 00:00:00 counts as +1 s.
  - The first good frame after reset or after o_lost never flags.
- When undefined, the port and its logic are absent.

Test Plan:
- Parameters: CS_ACTIVE_LOW=1, STABLE_CYCLES=4. Scan 12.34.56 with 16 cycles per position, positions 0..7 -> after the position 7 capture, o_valid pulses once and o_hh=12, o_mm=34, o_ss=56.
- Same scan with position 4 segments = 0x00 -> o_err pulses, o_valid stays 0, outputs hold 12/34/56.
- Scan 25.00.00 -> o_err pulses (hh range); outputs unchanged.
- Glitch: position 3 held 3 cycles then switch -> no capture. Also i_cs=8'b1111_1100 for 20 cycles -> no capture. The frame does not complete until a valid dwell occurs.
- Restart: scan positions 0..4 then position 0 again -> o_err pulses. A full subsequent frame 00.00.01 -> o_valid with 0/0/1.
- Stop scanning for TIMEOUT_CYCLES -> o_lost=1 and outputs hold. With the macro defined:
  - 23.59.59 then 00.00.00 -> o_tick_err=0.
  - 00.00.00 then 00.00.05 -> o_tick_err pulses.
